// File: rtl/line_stream_reader.sv
// Line memory read initiator: fetches num_lines 512-bit lines
// and streams each out as 16-bit words over valid/ready.
module line_stream_reader #(
  parameter int DATAW = 16,
  parameter int INW   = 512,
  parameter int ADDRW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ADDRW-1:0] base_addr,
  input  logic [15:0]      num_lines,
  output logic             busy,
  output logic             done,
  output logic             mem_write,
  output logic [ADDRW-1:0] mem_addr,
  output logic [INW-1:0]   mem_data_in,
  input  logic             mem_valid,
  input  logic [INW-1:0]   mem_data_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [DATAW-1:0] word_data,
  output logic             word_last
);

  localparam int NUMWORDS = INW / DATAW;
  localparam int IDXW     = $clog2(NUMWORDS);
  localparam int OFFW     = $clog2(INW / 8);

  localparam logic [IDXW-1:0] IDX_LAST =
    IDXW'(NUMWORDS - 1);
  localparam logic [ADDRW-1:0] LINE_BYTES =
    ADDRW'(INW / 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_STREAM,
    S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [15:0]      rem_q, rem_d;
  logic [INW-1:0]   buf_q, buf_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  logic [NUMWORDS-1:0][DATAW-1:0] words;
  logic [ADDRW-1:0]               base_line;
  logic                           unused_base;

  // Byte offset within a line is dropped on purpose.
  assign base_line   = {base_addr[ADDRW-1:OFFW],
                        {OFFW{1'b0}}};
  assign unused_base = ^base_addr[OFFW-1:0];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_lines != 16'd0) begin
            addr_d  = base_line;
            rem_d   = num_lines;
            state_d = S_REQ;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      // Memory settles one cycle after an address change.
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_valid) begin
          buf_d   = mem_data_out;
          idx_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (word_ready) begin
          if (idx_q == IDX_LAST) begin
            rem_d = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_d = S_FIN;
            end else begin
              addr_d  = addr_q + LINE_BYTES;
              state_d = S_REQ;
            end
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
    end
  end

  assign words       = buf_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign mem_write   = 1'b0;
  assign mem_data_in = '0;
  assign mem_addr    = addr_q;
  assign word_valid  = (state_q == S_STREAM);
  assign word_data   = words[idx_q];
  assign word_last   = (state_q == S_STREAM) &&
                       (idx_q == IDX_LAST) &&
                       (rem_q == 16'd1);

endmodule

// File: tb/tb_line_stream_reader.sv
// Directed bench for line_stream_reader with a word scoreboard
// and a behavioural line memory.
module tb_line_stream_reader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [31:0]  base_addr;
  logic [15:0]  num_lines;
  logic         busy;
  logic         done;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [511:0] mem_data_in;
  logic         mem_valid;
  logic [511:0] mem_data_out;
  logic         word_valid;
  logic         word_ready;
  logic [15:0]  word_data;
  logic         word_last;

  int checks   = 0;
  int failures = 0;

  logic [16:0] sb[$];
  logic [31:0] addrq[$];

  logic [15:0] key;
  int          lat;
  bit          rdy_rand;
  bit          spur;
  int          done_cnt;
  int          exp_done;
  int          wcount;
  int          mcnt;
  bit          prev_stall;
  logic [15:0] prev_data;
  logic        prev_last;
  logic [31:0] last_addr;

  line_stream_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .num_lines    (num_lines),
    .busy         (busy),
    .done         (done),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_valid    (mem_valid),
    .mem_data_out (mem_data_out),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .word_data    (word_data),
    .word_last    (word_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] wexp(
    input logic [31:0] a, input int i);
    return key + {5'd0, a[11:6], 5'd0} + 16'(i);
  endfunction

  // Behavioural memory: answers lat cycles after leaving STREAM/IDLE.
  always @(negedge clk) begin
    if (busy === 1'b1 && word_valid === 1'b0 &&
        done === 1'b0) begin
      mcnt++;
      if (mcnt == 1) begin
        chk("addr_expected", 64'(addrq.size() != 0), 64'd1);
        if (addrq.size() != 0)
          chk("mem_addr", 64'(mem_addr),
              64'(addrq.pop_front()));
        chk("mem_write", 64'(mem_write), 64'd0);
        chk("mem_data_in", 64'(mem_data_in === '0), 64'd1);
      end
      if (mcnt >= lat) begin
        mem_valid = 1'b1;
        for (int i = 0; i < 32; i++)
          mem_data_out[i*16 +: 16] = wexp(mem_addr, i);
      end else begin
        mem_valid = 1'b0;
      end
    end else begin
      mcnt = 0;
      if (spur && rst_n) begin
        mem_valid    = 1'($urandom_range(0, 1));
        mem_data_out = {16{$urandom()}};
      end else begin
        mem_valid = 1'b0;
      end
    end
  end

  // Consumer: drives ready and pops the scoreboard on transfers.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (done === 1'b1) done_cnt++;
      if (prev_stall) begin
        chk("stall_valid", 64'(word_valid), 64'd1);
        chk("stall_data", 64'(word_data), 64'(prev_data));
        chk("stall_last", 64'(word_last), 64'(prev_last));
      end
      word_ready = rdy_rand ? 1'($urandom_range(0, 1))
                            : 1'b1;
      if (word_valid === 1'b1) begin
        if (word_ready) begin
          logic [16:0] e;
          chk("word_expected", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("word_data", 64'(word_data), 64'(e[15:0]));
            chk("word_last", 64'(word_last), 64'(e[16]));
          end
          wcount++;
        end else begin
          prev_data = word_data;
          prev_last = word_last;
        end
        prev_stall = !word_ready;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic cmd(input logic [31:0] b,
                     input logic [15:0] n);
    logic [31:0] a;
    a = {b[31:6], 6'd0};
    for (int l = 0; l < int'(n); l++) begin
      addrq.push_back(a);
      last_addr = a;
      for (int i = 0; i < 32; i++)
        sb.push_back({(l == int'(n) - 1 && i == 31),
                      wexp(a, i)});
      a = a + 32'd64;
    end
    start     = 1'b1;
    base_addr = b;
    num_lines = n;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int d0;
    int c;
    d0 = done_cnt;
    c  = 0;
    while (done_cnt == d0 && c < lim) begin
      @(posedge clk);
      #2;
      c++;
    end
    chk("done_seen", 64'(done_cnt != d0), 64'd1);
    exp_done++;
    @(posedge clk);
    #2;
    chk("busy_after", 64'(busy), 64'd0);
    chk("done_count", 64'(done_cnt), 64'(exp_done));
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("addrq_empty", 64'(addrq.size()), 64'd0);
  endtask

  initial begin
    int w0;
    int c;
    logic [31:0] saved;
    rst_n        = 1'b0;
    start        = 1'b0;
    base_addr    = '0;
    num_lines    = '0;
    mem_valid    = 1'b0;
    mem_data_out = '0;
    word_ready   = 1'b0;
    key          = 16'hA000;
    lat          = 3;
    rdy_rand     = 1'b0;
    spur         = 1'b0;
    done_cnt     = 0;
    exp_done     = 0;
    wcount       = 0;
    mcnt         = 0;
    last_addr    = '0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(word_valid), 64'd0);
    chk("rst_last", 64'(word_last), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_data", 64'(word_data), 64'd0);
    chk("rst_wr", 64'(mem_write), 64'd0);
    chk("rst_wdata", 64'(mem_data_in === '0), 64'd1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // single line, words 0xA000 + i
    cmd(32'h0000_1000, 16'd1);
    wait_done(300);

    // unaligned base, three lines
    key = 16'h1234;
    lat = 2;
    cmd(32'h0000_2023, 16'd3);
    wait_done(600);

    // backpressure with stray mem_valid pulses
    key      = 16'h5A00;
    lat      = 1;
    rdy_rand = 1'b1;
    spur     = 1'b1;
    cmd(32'h0000_5000, 16'd2);
    wait_done(2000);
    rdy_rand = 1'b0;
    spur     = 1'b0;

    // zero lines: done next cycle, address untouched
    saved     = last_addr;
    start     = 1'b1;
    base_addr = 32'h0000_9000;
    num_lines = 16'd0;
    @(posedge clk);
    #1;
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_addr", 64'(mem_addr), 64'(saved));
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("zero_done_off", 64'(done), 64'd0);
    chk("zero_busy_off", 64'(busy), 64'd0);
    exp_done++;
    #1;

    // start while busy is ignored
    key = 16'h3300;
    lat = 4;
    cmd(32'h0000_3000, 16'd1);
    repeat (3) @(posedge clk);
    #2;
    start     = 1'b1;
    base_addr = 32'h0000_8000;
    num_lines = 16'd5;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done(300);
    repeat (10) @(posedge clk);
    #2;
    chk("ign_busy", 64'(busy), 64'd0);
    chk("ign_done_cnt", 64'(done_cnt), 64'(exp_done));

    // address wrap
    key = 16'h7000;
    lat = 2;
    cmd(32'hFFFF_FFC0, 16'd2);
    wait_done(600);

    // reset at word 10 of the second line
    key = 16'h4400;
    cmd(32'h0000_4000, 16'd2);
    w0 = wcount;
    c  = 0;
    while (wcount < w0 + 42 && c < 600) begin
      @(posedge clk);
      #2;
      c++;
    end
    chk("reached_w42", 64'(wcount >= w0 + 42), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_valid", 64'(word_valid), 64'd0);
    chk("mid_last", 64'(word_last), 64'd0);
    chk("mid_addr", 64'(mem_addr), 64'd0);
    chk("mid_data", 64'(word_data), 64'd0);
    chk("mid_wr", 64'(mem_write), 64'd0);
    chk("mid_wdata", 64'(mem_data_in === '0), 64'd1);
    sb.delete();
    addrq.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("mid_no_done", 64'(done_cnt), 64'(exp_done));
    key = 16'h6600;
    cmd(32'h0000_6000, 16'd1);
    wait_done(300);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
